// File: rtl/axi32_ctl_arbiter.sv
// axi32_ctl_arbiter: round-robin arbiter sharing one AXI32 CTL-side
// transaction controller between NREQ requesters.
// Latency: Grant is registered, 1 cycle after ReqExec is sampled in idle;
// routed status (Req*) and forwarded controls (CTL*) are combinational.
// Backpressure: no queueing state; a losing requester keeps ReqExec high
// until it is granted. The grant is held until the controller signals CTLEnd.
//
// Optional feature: define AXI32_CTL_ARBITER_WDOG_EN to add a transaction
// watchdog. WdogErr sets once a grant has been held WDOG_CYCLES cycles and
// stays set until Reset. Without the macro, WdogErr is tied to 0.
//
// Ports:
//   AXIClock, Reset          clock (rising edge), async active-high reset
//   ReqExec/ReqWrite/ReqWLast per-requester request controls (NREQ bits)
//   Grant                    registered one-hot grant
//   ReqStart..ReqWBErr       controller status routed to the granted requester
//   CTLExec/CTLWrite/CTLWLast controls forwarded to the controller
//   CTLStart..CTLWBErr       status from the controller
//   Busy                     arbiter is in a transaction (grant held or release)
//   WdogErr                  sticky watchdog flag
module axi32_ctl_arbiter #(
  parameter int NREQ        = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            AXIClock,
  input  logic            Reset,
  input  logic [NREQ-1:0] ReqExec,
  input  logic [NREQ-1:0] ReqWrite,
  input  logic [NREQ-1:0] ReqWLast,
  output logic [NREQ-1:0] Grant,
  output logic [NREQ-1:0] ReqStart,
  output logic [NREQ-1:0] ReqEnd,
  output logic [NREQ-1:0] ReqReady,
  output logic [NREQ-1:0] ReqPutEn,
  output logic [NREQ-1:0] ReqGetEn,
  output logic [NREQ-1:0] ReqRBErr,
  output logic [NREQ-1:0] ReqWBErr,
  output logic            CTLExec,
  output logic            CTLWrite,
  output logic            CTLWLast,
  input  logic            CTLStart,
  input  logic            CTLEnd,
  input  logic            CTLReady,
  input  logic            CTLPutEn,
  input  logic            CTLGetEn,
  input  logic            CTLRBErr,
  input  logic            CTLWBErr,
  output logic            Busy,
  output logic            WdogErr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_OWN     = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [IW-1:0]   gidx_q, gidx_nxt;
  logic [IW-1:0]   ptr_q, ptr_nxt;
  logic [IW-1:0]   pick, cand;
  logic            pick_vld;
  logic            ctl_exec, ctl_write, ctl_wlast;

  // Round-robin scan: first requester at or after ptr_q, wrapping mod NREQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!pick_vld && ReqExec[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge AXIClock or posedge Reset) begin
    if (Reset) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      gidx_q  <= gidx_nxt;
      ptr_q   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    gidx_nxt  = gidx_q;
    ptr_nxt   = ptr_q;
    ctl_exec  = 1'b0;
    ctl_write = 1'b0;
    ctl_wlast = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          gidx_nxt        = pick;
          state_nxt       = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        ctl_exec  = ReqExec[gidx_q];
        ctl_write = ReqWrite[gidx_q];
        if (CTLStart) begin
          state_nxt = ARB_OWN;
        end else if (!ReqExec[gidx_q]) begin
          // Withdrawn before the controller started: give up the grant
          // without advancing the pointer, so the same requester keeps priority.
          grant_nxt = '0;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        ctl_exec  = ReqExec[gidx_q];
        ctl_write = ReqWrite[gidx_q];
        ctl_wlast = ReqWLast[gidx_q];
        if (CTLEnd) begin
          grant_nxt = '0;
          ptr_nxt   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
          state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // One dead cycle so the controller always sees exec low between owners.
        state_nxt = ARB_IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign Grant    = grant_q;
  assign CTLExec  = ctl_exec;
  assign CTLWrite = ctl_write;
  assign CTLWLast = ctl_wlast;
  assign Busy     = (state != ARB_IDLE);

  // Status routing: only the granted requester ever sees controller status.
  assign ReqStart = {NREQ{CTLStart}} & grant_q;
  assign ReqEnd   = {NREQ{CTLEnd}}   & grant_q;
  assign ReqReady = {NREQ{CTLReady}} & grant_q;
  assign ReqPutEn = {NREQ{CTLPutEn}} & grant_q;
  assign ReqGetEn = {NREQ{CTLGetEn}} & grant_q;
  assign ReqRBErr = {NREQ{CTLRBErr}} & grant_q;
  assign ReqWBErr = {NREQ{CTLWBErr}} & grant_q;

`ifdef AXI32_CTL_ARBITER_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_cnt;
  logic          wdog_err;
  logic          wdog_active;

  assign wdog_active = (state == ARB_ISSUE) || (state == ARB_OWN);

  // Counter saturates at WDOG_CYCLES; the flag sets on the edge the counter
  // reaches the limit and only Reset clears it.
  always_ff @(posedge AXIClock or posedge Reset) begin
    if (Reset) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ARB_IDLE && state_nxt == ARB_ISSUE) begin
        wdog_cnt <= '0;
      end else if (wdog_active && wdog_cnt != CW'(WDOG_CYCLES)) begin
        wdog_cnt <= wdog_cnt + CW'(1);
      end
      if (wdog_active && wdog_cnt == CW'(WDOG_CYCLES - 1)) begin
        wdog_err <= 1'b1;
      end
    end
  end

  assign WdogErr = wdog_err;
`else
  logic [31:0] wdog_cycles_unused;
  assign wdog_cycles_unused = WDOG_CYCLES;
  assign WdogErr = 1'b0;
`endif

endmodule

// File: tb/tb_axi32_ctl_arbiter.sv
module tb_axi32_ctl_arbiter;
  localparam int NREQ = 2;
  localparam int WDOG = 16;
`ifdef AXI32_CTL_ARBITER_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            AXIClock = 1'b0;
  logic            Reset;
  logic [NREQ-1:0] ReqExec, ReqWrite, ReqWLast;
  logic [NREQ-1:0] Grant, ReqStart, ReqEnd, ReqReady, ReqPutEn, ReqGetEn, ReqRBErr, ReqWBErr;
  logic            CTLExec, CTLWrite, CTLWLast;
  logic            CTLStart, CTLEnd, CTLReady, CTLPutEn, CTLGetEn, CTLRBErr, CTLWBErr;
  logic            Busy, WdogErr;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;  // reference round-robin pointer

  always #5 AXIClock = ~AXIClock;

  axi32_ctl_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
    .AXIClock(AXIClock), .Reset(Reset),
    .ReqExec(ReqExec), .ReqWrite(ReqWrite), .ReqWLast(ReqWLast),
    .Grant(Grant), .ReqStart(ReqStart), .ReqEnd(ReqEnd), .ReqReady(ReqReady),
    .ReqPutEn(ReqPutEn), .ReqGetEn(ReqGetEn), .ReqRBErr(ReqRBErr), .ReqWBErr(ReqWBErr),
    .CTLExec(CTLExec), .CTLWrite(CTLWrite), .CTLWLast(CTLWLast),
    .CTLStart(CTLStart), .CTLEnd(CTLEnd), .CTLReady(CTLReady), .CTLPutEn(CTLPutEn),
    .CTLGetEn(CTLGetEn), .CTLRBErr(CTLRBErr), .CTLWBErr(CTLWBErr),
    .Busy(Busy), .WdogErr(WdogErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge AXIClock);
    @(negedge AXIClock);
  endtask

  // Winner = first requester at or after the pointer, wrapping.
  function automatic int model_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (((m >> idx) & 2'b01) != 2'b00) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int w);
    return 32'(1) << w;
  endfunction

  task automatic start_txn(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] wr, output int w);
    w = model_pick(ptr_m, mask);
    ReqWrite = wr;
    ReqExec  = mask;
    #1;
    chk("pre_grant", 32'(Grant), 0);
    chk("pre_exec", 32'(CTLExec), 0);
    tick;
    chk("grant", 32'(Grant), onehot(w));
    chk("busy_on", 32'(Busy), 1);
    chk("issue_exec", 32'(CTLExec), 1);
    chk("issue_write", 32'(CTLWrite), 32'(wr[w[0]]));
    CTLStart = 1'b1;
    #1 chk("req_start", 32'(ReqStart), onehot(w));
    tick;
    CTLStart = 1'b0;
  endtask

  task automatic do_beats(input int w, input int n, input logic wdir, input int gap_max);
    int seen;
    seen = 0;
    for (int b = 0; b < n; b++) begin
      ReqWLast = '0;
      if (wdir) begin
        CTLGetEn = 1'b1;
        ReqWLast[w[0]] = (b == n - 1);
      end else begin
        CTLPutEn = 1'b1;
      end
      #1;
      chk("own_write", 32'(CTLWrite), 32'(wdir));
      chk("own_wlast", 32'(CTLWLast), 32'(wdir && (b == n - 1)));
      if (wdir) chk("req_geten", 32'(ReqGetEn), onehot(w));
      else      chk("req_puten", 32'(ReqPutEn), onehot(w));
      if (wdir ? ReqGetEn[w[0]] : ReqPutEn[w[0]]) seen++;
      tick;
      CTLGetEn = 1'b0;
      CTLPutEn = 1'b0;
      ReqWLast = '0;
      repeat ($urandom_range(0, gap_max)) begin
        #1 chk("gap_exec", 32'(CTLExec), 1);
        tick;
      end
    end
    chk("beat_count", 32'(seen), 32'(n));
  endtask

  task automatic finish_txn(input int w);
    logic rb, wb;
    rb = 1'($urandom_range(0, 1));
    wb = 1'($urandom_range(0, 1));
    CTLReady = 1'b1; CTLRBErr = rb; CTLWBErr = wb;
    #1;
    chk("req_ready", 32'(ReqReady), onehot(w));
    chk("req_rberr", 32'(ReqRBErr), rb ? onehot(w) : 0);
    chk("req_wberr", 32'(ReqWBErr), wb ? onehot(w) : 0);
    tick;
    CTLReady = 1'b0; CTLRBErr = 1'b0; CTLWBErr = 1'b0;
    ReqExec[w[0]] = 1'b0;
    CTLEnd = 1'b1;
    #1;
    chk("drop_exec", 32'(CTLExec), 0);
    chk("req_end", 32'(ReqEnd), onehot(w));
    tick;
    CTLEnd = 1'b0;
    ptr_m = (w + 1) % NREQ;
    #1;
    chk("rel_grant", 32'(Grant), 0);
    chk("rel_exec", 32'(CTLExec), 0);
    chk("rel_write", 32'(CTLWrite), 0);
    chk("rel_busy", 32'(Busy), 1);
    tick;
    #1;
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_grant", 32'(Grant), 0);
    chk("wdog_quiet", 32'(WdogErr), 0);
  endtask

  initial begin
    int w;
    logic [NREQ-1:0] mask, wr;
    int n;
    Reset = 1'b1;
    ReqExec = '0; ReqWrite = '0; ReqWLast = '0;
    CTLStart = 0; CTLEnd = 0; CTLReady = 0; CTLPutEn = 0; CTLGetEn = 0; CTLRBErr = 0; CTLWBErr = 0;
    repeat (2) @(negedge AXIClock);
    #1;
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_wdog", 32'(WdogErr), 0);
    chk("rst_exec", 32'(CTLExec), 0);
    Reset = 1'b0;
    tick;

    // Single read transaction from requester 0, 4 put beats.
    start_txn(2'b01, 2'b00, w);
    chk("first_winner", 32'(w), 0);
    do_beats(w, 4, 1'b0, 0);
    finish_txn(w);

    // Both requesting for 3 transactions: grants alternate.
    for (int t = 0; t < 3; t++) begin
      start_txn(2'b11, 2'b00, w);
      do_beats(w, 2, 1'b0, 0);
      finish_txn(w);
    end

    // Write from requester 1, WLast on beat 3.
    start_txn(2'b10, 2'b10, w);
    do_beats(w, 3, 1'b1, 0);
    finish_txn(w);
    #1 chk("idle_write_zero", 32'(CTLWrite), 0);

    // Withdraw before CTLStart: grant clears, pointer unchanged.
    ReqExec = 2'b01;
    tick;
    chk("wd_grant", 32'(Grant), 1);
    ReqExec = 2'b00;
    #1 chk("wd_exec", 32'(CTLExec), 0);
    tick;
    chk("wd_grant_clr", 32'(Grant), 0);
    chk("wd_busy", 32'(Busy), 0);
    start_txn(2'b11, 2'b00, w);
    chk("wd_ptr_kept", 32'(w), 0);
    do_beats(w, 2, 1'b0, 0);
    finish_txn(w);

    // Reset mid-burst while requester 1 owns (pointer at 1).
    start_txn(2'b11, 2'b00, w);
    CTLPutEn = 1'b1;
    tick;
    Reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(Grant), 0);
    chk("mid_rst_busy", 32'(Busy), 0);
    chk("mid_rst_exec", 32'(CTLExec), 0);
    chk("mid_rst_puten", 32'(ReqPutEn), 0);
    CTLPutEn = 1'b0; ReqExec = '0;
    ptr_m = 0;
    tick;
    Reset = 1'b0;
    tick;
    start_txn(2'b11, 2'b00, w);
    chk("rst_ptr_zero", 32'(w), 0);
    do_beats(w, 1, 1'b0, 0);
    finish_txn(w);

    // Status with no grant never reaches requesters.
    CTLPutEn = 1'b1; CTLReady = 1'b1;
    #1;
    chk("nogrant_puten", 32'(ReqPutEn), 0);
    chk("nogrant_ready", 32'(ReqReady), 0);
    CTLPutEn = 1'b0; CTLReady = 1'b0;

    // Randomized traffic; waiting requesters stay asserted.
    for (int it = 0; it < 24; it++) begin
      mask = ReqExec | NREQ'($urandom_range(1, 3));
      wr   = NREQ'($urandom_range(0, 3));
      start_txn(mask, wr, w);
      n = $urandom_range(1, 4);
      do_beats(w, n, wr[w[0]], 1);
      finish_txn(w);
    end

    // Transaction that never ends: watchdog behaviour.
    ReqExec = '0;
    #1;
    start_txn(2'b01, 2'b00, w);
    repeat (WDOG - 2) tick;
    chk("wdog_before", 32'(WdogErr), 0);
    tick;
    chk("wdog_at_limit", 32'(WdogErr), 32'(WD_EN));
    repeat (5) tick;
    chk("wdog_sticky", 32'(WdogErr), 32'(WD_EN));
    chk("wdog_grant_held", 32'(Grant), 1);
    Reset = 1'b1;
    #1 chk("wdog_rst", 32'(WdogErr), 0);
    ReqExec = '0;
    tick;
    Reset = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
